// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared states, RAM selects and sizing helpers for the matrix-multiply host sequencer
package mm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    START,
    WAIT_ACK,
    WAIT_DONE,
    RD_ADDR,
    RD_WAIT,
    RD_OUT
  } mm_state_e;

  localparam logic [1:0] SEL_X = 2'd0;
  localparam logic [1:0] SEL_Y = 2'd1;
  localparam logic [1:0] SEL_Z = 2'd2;

  function automatic int x_cnt(input int x_rows, input int inner);
    return x_rows * inner;
  endfunction

  function automatic int y_cnt(input int inner, input int y_cols);
    return inner * y_cols;
  endfunction

  function automatic int z_cnt(input int x_rows, input int y_cols);
    return x_rows * y_cols;
  endfunction

endpackage

// File: rtl/mm_rd_skid.sv
// rtl/mm_rd_skid.sv - result capture register with valid/ready hold for the Z read-out stream
module mm_rd_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  cap_last,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  // Load a RAM word when asked; hold data/last until the downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (cap_en) begin
      m_valid <= 1'b1;
      m_data  <= cap_data;
      m_last  <= cap_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/mm_host_sequencer.sv
// rtl/mm_host_sequencer.sv - loads X/Y RAMs from a word stream, kicks the multiplier, streams Z back out
module mm_host_sequencer
  import mm_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 2,
  parameter int Y_COLS        = 2,
  parameter int X_COLS_Y_ROWS = 2,
  parameter int ACK_TIMEOUT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  mm_start,
  output logic [ADDR_WIDTH-1:0] mm_ram_addr,
  output logic                  mm_ram_wen,
  output logic [1:0]            mm_ram_sel,
  output logic [DATA_WIDTH-1:0] mm_ram_data_in,
  input  logic                  mm_busy,
  input  logic [DATA_WIDTH-1:0] mm_ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int X_CNT = x_cnt(X_ROWS, X_COLS_Y_ROWS);
  localparam int Y_CNT = y_cnt(X_COLS_Y_ROWS, Y_COLS);
  localparam int Z_CNT = z_cnt(X_ROWS, Y_COLS);
  // One spare bit so terminal-count compares never alias through a wrap.
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] X_LAST   = CW'(X_CNT - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(Y_CNT - 1);
  localparam logic [CW-1:0] Z_LAST   = CW'(Z_CNT - 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

  mm_state_e             state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [TW-1:0]         ack_q, ack_n;
  logic                  s_hs, m_hs;
  logic                  start_n, wen_n, done_n, err_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [1:0]            sel_n;
  logic [DATA_WIDTH-1:0] wdata_n;

  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;

  // Next state plus the next value of every registered RAM/control output.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ack_n   = ack_q;
    start_n = 1'b0;
    wen_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = s_hs ? 1'b0 : err;
    addr_n  = mm_ram_addr;
    sel_n   = mm_ram_sel;
    wdata_n = mm_ram_data_in;
    unique case (state_q)
      IDLE, LOAD_X: begin
        if (s_hs) begin
          wen_n   = 1'b1;
          sel_n   = SEL_X;
          addr_n  = ADDR_WIDTH'(cnt_q);
          wdata_n = s_data;
          if (cnt_q == X_LAST) begin
            cnt_n   = '0;
            state_n = LOAD_Y;
          end else begin
            cnt_n   = cnt_q + 1'b1;
            state_n = LOAD_X;
          end
        end
      end
      LOAD_Y: begin
        if (s_hs) begin
          wen_n   = 1'b1;
          sel_n   = SEL_Y;
          addr_n  = ADDR_WIDTH'(cnt_q);
          wdata_n = s_data;
          if (cnt_q == Y_LAST) begin
            cnt_n   = '0;
            state_n = START;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        start_n = 1'b1;
        ack_n   = '0;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (mm_busy) begin
          state_n = WAIT_DONE;
        end else if (ack_q == ACK_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          ack_n = ack_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!mm_busy) begin
          cnt_n   = '0;
          addr_n  = '0;
          sel_n   = SEL_Z;
          state_n = RD_ADDR;
        end
      end
      RD_ADDR: state_n = RD_WAIT;
      RD_WAIT: state_n = RD_OUT;
      RD_OUT: begin
        if (m_hs) begin
          if (cnt_q == Z_LAST) begin
            cnt_n   = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n   = cnt_q + 1'b1;
            addr_n  = ADDR_WIDTH'(cnt_q + 1'b1);
            sel_n   = SEL_Z;
            state_n = RD_ADDR;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and all interface outputs; s_ready/busy follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ack_q          <= '0;
      s_ready        <= 1'b0;
      busy           <= 1'b0;
      mm_start       <= 1'b0;
      mm_ram_wen     <= 1'b0;
      mm_ram_addr    <= '0;
      mm_ram_sel     <= '0;
      mm_ram_data_in <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state_q        <= state_n;
      cnt_q          <= cnt_n;
      ack_q          <= ack_n;
      s_ready        <= (state_n == IDLE) || (state_n == LOAD_X) || (state_n == LOAD_Y);
      busy           <= (state_n != IDLE);
      mm_start       <= start_n;
      mm_ram_wen     <= wen_n;
      mm_ram_addr    <= addr_n;
      mm_ram_sel     <= sel_n;
      mm_ram_data_in <= wdata_n;
      done           <= done_n;
      err            <= err_n;
    end
  end

  mm_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_skid (
    .clk     (clk),
    .rst_n   (rst),
    .cap_en  (state_q == RD_WAIT),
    .cap_data(mm_ram_data_out),
    .cap_last(cnt_q == Z_LAST),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last)
  );

endmodule

// File: tb/tb_mm_host_sequencer.sv
// tb/tb_mm_host_sequencer.sv - directed self-checking bench for mm_host_sequencer
module tb_mm_host_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        mm_start;
  logic [3:0]  mm_ram_addr;
  logic        mm_ram_wen;
  logic [1:0]  mm_ram_sel;
  logic [31:0] mm_ram_data_in;
  logic        mm_busy;
  logic [31:0] mm_ram_data_out = '0;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_z [4] = '{32'd7, 32'd10, 32'd15, 32'd22};

  always #5 clk = ~clk;

  mm_host_sequencer dut (
    .clk            (clk),
    .rst            (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .mm_start       (mm_start),
    .mm_ram_addr    (mm_ram_addr),
    .mm_ram_wen     (mm_ram_wen),
    .mm_ram_sel     (mm_ram_sel),
    .mm_ram_data_in (mm_ram_data_in),
    .mm_busy        (mm_busy),
    .mm_ram_data_out(mm_ram_data_out),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // Behavioural 2x2 multiplier with X/Y/Z RAMs; no_ack suppresses busy entirely.
  logic [31:0] xm [16];
  logic [31:0] ym [16];
  logic [31:0] zm [16];
  logic [2:0]  bcnt = '0;
  logic        no_ack = 1'b0;
  assign mm_busy = (bcnt != 0);

  always @(posedge clk) begin
    if (mm_ram_wen && mm_ram_sel == 2'd0) xm[mm_ram_addr] <= mm_ram_data_in;
    if (mm_ram_wen && mm_ram_sel == 2'd1) ym[mm_ram_addr] <= mm_ram_data_in;
    if (mm_ram_sel == 2'd2) mm_ram_data_out <= zm[mm_ram_addr];
    if (!rst_n) begin
      bcnt <= '0;
    end else if (mm_start && !no_ack) begin
      bcnt <= 3'd3;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          zm[i*2+j] <= xm[i*2] * ym[j] + xm[i*2+1] * ym[2+j];
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 3'd1;
    end
  end

  // Interface monitor: RAM writes, result beats, pulses and cycle stamps.
  logic [37:0] wlog [$];
  logic [32:0] blog [$];
  int   cyc = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;
  int   start_cyc = 0;
  int   err_cyc = 0;
  logic err_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mm_ram_wen) wlog.push_back({mm_ram_sel, mm_ram_addr, mm_ram_data_in});
    if (m_valid && m_ready) blog.push_back({m_last, m_data});
    if (mm_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err && !err_d) err_cyc <= cyc;
    err_d <= err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wlog.delete();
    blog.delete();
    start_cnt = 0;
    done_cnt = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] d, input bit gap);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("s_ready_wait", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_all(input bit gap);
    for (int i = 0; i < 8; i++) send_word(32'(i % 4 + 1), gap);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_seen", 32'(done_cnt >= target), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mvalid(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!m_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(m_valid), 32'd1);
  endtask

  task automatic check_results(input string tag);
    check($sformatf("%s_beats", tag), 32'(blog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < blog.size()) begin
        check($sformatf("%s_data%0d", tag, i), blog[i][31:0], exp_z[i]);
        check($sformatf("%s_last%0d", tag, i), 32'(blog[i][32]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    check($sformatf("%s_done_once", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s_err", tag), 32'(err), 32'd0);
  endtask

  initial begin
    int t;
    logic [37:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_wen", 32'(mm_ram_wen), 32'd0);
    check("rst_start", 32'(mm_start), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back load, always-ready sink
    clear_logs();
    m_ready = 1'b1;
    load_all(1'b0);
    wait_done(1);
    check_results("plain");
    check("plain_start_once", 32'(start_cnt), 32'd1);

    // Gapped load, then a 5-cycle stall on the second result
    clear_logs();
    m_ready = 1'b0;
    load_all(1'b1);
    wait_mvalid("gap_first_valid");
    check("gap_wr_count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size()) begin
        w = wlog[i];
        check($sformatf("gap_wr%0d", i), 32'(w), 32'({(i < 4) ? 2'd0 : 2'd1, 4'(i % 4), 32'(i % 4 + 1)}));
      end
    end
    check("gap_start_once", 32'(start_cnt), 32'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    wait_mvalid("stall_second_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", i), 32'(m_valid), 32'd1);
      check($sformatf("stall_data%0d", i), m_data, 32'd10);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_done(1);
    check_results("stall");

    // Multiplier never acknowledges
    clear_logs();
    no_ack = 1'b1;
    load_all(1'b0);
    t = 0;
    while (!err && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("to_err_set", 32'(err), 32'd1);
    @(negedge clk);
    #1;
    check("to_err_delay", 32'(err_cyc - start_cyc), 32'd4);
    check("to_idle_busy", 32'(busy), 32'd0);
    check("to_idle_s_ready", 32'(s_ready), 32'd1);
    check("to_no_beats", 32'(blog.size()), 32'd0);
    no_ack = 1'b0;
    @(posedge clk);
    #1;
    send_word(32'd1, 1'b0);
    @(negedge clk);
    check("to_err_cleared", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) send_word(32'(i % 4 + 1), 1'b0);
    wait_done(1);
    check_results("after_to");

    // Asynchronous reset mid LOAD_Y, while a Y write is on the interface
    clear_logs();
    for (int i = 0; i < 6; i++) send_word(32'(i % 4 + 1), 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstY_wen", 32'(mm_ram_wen), 32'd0);
    check("rstY_sel", 32'(mm_ram_sel), 32'd0);
    check("rstY_addr", 32'(mm_ram_addr), 32'd0);
    check("rstY_busy", 32'(busy), 32'd0);
    check("rstY_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    load_all(1'b0);
    wait_done(1);
    check_results("post_rstY");

    // Asynchronous reset while a result is waiting in RD_OUT
    clear_logs();
    m_ready = 1'b0;
    load_all(1'b0);
    wait_mvalid("rdout_valid");
    check("rdout_data_before", m_data, 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstZ_m_valid", 32'(m_valid), 32'd0);
    check("rstZ_m_data", m_data, 32'd0);
    check("rstZ_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    clear_logs();
    load_all(1'b0);
    wait_done(1);
    check_results("post_rstZ");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mm_host_sequencer.md
Name: mm_host_sequencer

Overview:
Host-side initiator for the matrix-multiply RAM/start/busy interface. It accepts a valid/ready word stream, writes the first X_ROWS*X_COLS_Y_ROWS words into X RAM (sel 0) and the next X_COLS_Y_ROWS*Y_COLS words into Y RAM (sel 1). It then pulses start, waits for busy to rise and fall, and streams the X_ROWS*Y_COLS result words back out of Z RAM (sel 2) on a valid/ready/last output stream. It sits between a host/DMA stream and matrix_multiply_top.

Parameters:
ADDR_WIDTH, 4, RAM address width; 2^ADDR_WIDTH must be >= the largest matrix element count
DATA_WIDTH, 32, word width
X_ROWS, 2, rows of X
Y_COLS, 2, columns of Y
X_COLS_Y_ROWS, 2, inner dimension
ACK_TIMEOUT, 4, cycles allowed after start for busy to rise

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset)
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&&s_ready
s_data  in  DATA_WIDTH  input word (X row-major, then Y row-major)
m_valid  out  1  result word valid
m_ready  in  1  downstream accepts result
m_data  out  DATA_WIDTH  result word (Z row-major)
m_last  out  1  high with final Z word
mm_start  out  1  one-cycle start pulse
mm_ram_addr  out  ADDR_WIDTH  RAM address
mm_ram_wen  out  1  RAM write enable
mm_ram_sel  out  2  0=X, 1=Y, 2=Z
mm_ram_data_in  out  DATA_WIDTH  RAM write data
mm_busy  in  1  multiplier busy
mm_ram_data_out  in  DATA_WIDTH  RAM read data, valid 1 cycle after address
busy  out  1  sequencer not in IDLE
done  out  1  one-cycle pulse after last Z beat accepted
err  out  1  sticky: busy never rose within ACK_TIMEOUT; cleared by reset or next accepted s_data beat

Behaviour:
- All outputs are registered. Reset (rst=0, asynchronous, any state) forces IDLE and drives every output to 0, including the counter and err. A RAM write in flight when reset asserts is dropped.
- States: IDLE, LOAD_X, LOAD_Y, START, WAIT_ACK, WAIT_DONE, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE: s_ready=1. The first handshake writes X[0] and moves to LOAD_X with counter=1.
- LOAD_X / LOAD_Y: s_ready=1. Each handshake drives, on the next cycle, mm_ram_wen=1, addr=counter, sel=0/1, and data_in=s_data. wen is 0 on cycles with no handshake.
  - After X word X_ROWS*X_COLS_Y_ROWS-1 is accepted: counter clears, state goes to LOAD_Y.
  - After the last Y word: go to START.
  - s_valid gaps stall without side effects.
- START: s_ready=0. mm_start=1 for exactly one cycle, issued the cycle after the final Y write is on the interface (write/start never coincide). Then WAIT_ACK.
- WAIT_ACK: mm_busy=1 moves to WAIT_DONE. After ACK_TIMEOUT cycles without mm_busy: set err, return to IDLE, no output beats.
- WAIT_DONE: mm_busy=0 moves to RD_ADDR with counter=0.
- RD_ADDR: drive addr=counter, sel=2, wen=0. Next state RD_WAIT.
- RD_WAIT: capture mm_ram_data_out into m_data. Next state RD_OUT.
- RD_OUT: m_valid=1, with m_last=1 when counter==X_ROWS*Y_COLS-1.
  - m_data and m_last are held stable until m_ready.
  - On handshake: m_valid=0 next cycle; if not last, counter++ and go to RD_ADDR; if last, pulse done and go to IDLE.
- Throughput: 1 write/cycle on load; 3 cycles/result word plus m_ready stall.
- Counter width is ADDR_WIDTH+1, so the terminal-count compare never wraps.
- s_data arriving during START..RD_OUT is not accepted (s_ready=0).

Decomposition:
- Package mm_pkg holds:
  - state enum
  - RAM select constants SEL_X=0, SEL_Y=1, SEL_Z=2
  - element-count localparam functions (X_CNT, Y_CNT, Z_CNT)
- One sub-module, mm_rd_skid: the RD_WAIT/RD_OUT capture register plus valid/ready hold. All else is a single FSM in the top.

Test Plan:
- Load X=1,2,3,4 and Y=1,2,3,4 into a real 2x2 matrix_multiply_top, m_ready=1 -> m_data 7,10,15,22, m_last only on 22, done pulses once, err=0.
- Same load with s_valid toggling every other cycle -> identical RAM writes (addr 0..3 sel 0, then addr 0..3 sel 1), no wen on gap cycles, single mm_start pulse.
- m_ready held 0 for 5 cycles on the second result -> m_data stays 10 with m_valid=1 throughout; no beat lost or duplicated.
- Responder model whose busy never rises -> err=1 after 4 cycles in WAIT_ACK, back in IDLE, no m_valid; the next accepted s_data beat clears err.
- rst=0 asserted mid LOAD_Y and again mid RD_OUT -> all outputs 0 immediately (asynchronous); a fresh full load afterwards yields 7,10,15,22.
